// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bo = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock with a valid/ready handshake on each side.
// Optional macro SERIAL_SUB_SAT_EN: a borrowing result saturates diff to zero (bout still 1).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic               bit_d;
    logic               bit_bo;
    logic [WIDTH-1:0]   result_w;

    full_subtractor u_cell (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .bin (br_q),
        .d   (bit_d),
        .bo  (bit_bo)
    );

    // The minuend register doubles as the result register: result bits enter at the top
    // as operand bits leave at the bottom, so after WIDTH shifts it holds the difference.
    assign result_w = {bit_d, a_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d  = result_w;
                b_d  = {1'b0, b_q[WIDTH-1:1]};
                br_d = bit_bo;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    bout_d  = bit_bo;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d  = bit_bo ? '0 : result_w;
`else
                    diff_d  = result_w;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model, per-cycle monitor,
// directed boundary cases and randomized operations.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    bit           mon_en = 1'b0;
    bit           busy = 1'b0;
    int           cyc = 0;
    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Plain integer arithmetic: the borrow is simply "the true difference is negative".
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                                  output logic [W-1:0] d, output logic bo);
        int r;
        r  = int'(x) - int'(y) - int'(bi);
        bo = (r < 0);
        d  = W'(r + (1 << W));
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = '0;
`endif
    endfunction

    // Transaction-level model: accepted op becomes visible W+1 cycles after its handshake cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            cyc  = 0;
        end else if (busy && cyc >= W + 1) begin
            if (out_ready) busy = 1'b0;
        end else if (busy) begin
            cyc++;
        end else if (in_valid) begin
            busy = 1'b1;
            cyc  = 1;
            model(a, b, bin, exp_diff, exp_bout);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_out_valid", out_valid, busy && cyc >= W + 1);
            chk("mon_in_ready", in_ready, !busy);
            if (busy && cyc >= W + 1) begin
                chk("mon_diff", diff, exp_diff);
                chk("mon_bout", bout, exp_bout);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                          input int hold, input bit pulse, input bit lit,
                          input logic [W-1:0] ld, input logic lb, input int rst_at);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = xa; b = xb; bin = xbin;
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (pulse && lat == 3) begin
                in_valid = 1'b1; a = ~xa; b = xb + 8'd1; bin = ~xbin;
            end else begin
                in_valid = 1'b0;
            end
            if (rst_at > 0 && lat == rst_at) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("rst_out_valid", out_valid, 1'b0);
                chk("rst_in_ready", in_ready, 1'b1);
                chk("rst_diff", diff, '0);
                chk("rst_bout", bout, 1'b0);
                repeat (W + 3) @(negedge clk);
                return;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            chk("timeout_out_valid", out_valid, 1'b1);
            return;
        end
        if (lit) begin
            chk("latency", lat, W + 1);
            chk("lit_diff", diff, ld);
            chk("lit_bout", bout, lb);
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                in_valid = 1'b1; a = xb; b = xa; bin = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (lit && hold > 0) begin
            chk("hold_diff", diff, ld);
            chk("hold_bout", bout, lb);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] pd;
        logic         pb;
        logic [W-1:0] sat_fe;
        logic [W-1:0] sat_ff;

        model(8'h05, 8'h03, 1'b0, pd, pb);
        chk("model_pin_diff", pd, 8'h02);
        chk("model_pin_bout", pb, 1'b0);
        model(8'h10, 8'h01, 1'b0, pd, pb);
        chk("model_pin2_diff", pd, 8'h0F);

`ifdef SERIAL_SUB_SAT_EN
        sat_fe = 8'h00;
        sat_ff = 8'h00;
`else
        sat_fe = 8'hFE;
        sat_ff = 8'hFF;
`endif

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_diff", diff, '0);
        chk("reset_bout", bout, 1'b0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b1, 8'h02, 1'b0, 0);
        run_op(8'h03, 8'h05, 1'b0, 1, 1'b0, 1'b1, sat_fe, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b1, sat_ff, 1'b1, 0);
        run_op(8'hFF, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'hFF, 1'b0, 0);
        run_op(8'h5A, 8'h5A, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 0);
        run_op(8'hC3, 8'h21, 1'b0, 5, 1'b1, 1'b1, 8'hA2, 1'b0, 0);
        run_op(8'h37, 8'h12, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 4);
        run_op(8'h10, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h0F, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), 1'b0, '0, 1'b0, 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning operand/result bit width (legal range 2..64).
REQ-002 The block SHALL provide port clk, input, 1, single clock; all logic is rising-edge.
REQ-003 The block SHALL provide port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL provide port in_valid, input, 1, operands present.
REQ-005 The block SHALL provide port in_ready, output, 1, block can accept operands.
REQ-006 The block SHALL provide ports a and b, input, WIDTH each, minuend and subtrahend.
REQ-007 The block SHALL provide port bin, input, 1, borrow-in.
REQ-008 The block SHALL provide port out_valid, output, 1, result present.
REQ-009 The block SHALL provide port out_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL provide port diff, output, WIDTH, result a-b-bin mod 2^WIDTH.
REQ-011 The block SHALL provide port bout, output, 1, final borrow-out (1 when a < b+bin).

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-013 An in_valid&&in_ready cycle SHALL capture a, b and bin into shift registers, clear the bit counter and move IDLE->RUN.
REQ-014 RUN SHALL process one bit per cycle, LSB first, via a full-subtractor cell: d=a^b^br, br_next=(~a&b)|(~(a^b)&br), with br seeded from bin.
REQ-015 RUN SHALL last exactly WIDTH cycles; on the last bit (counter==WIDTH-1) the FSM SHALL move to DONE, so out_valid rises WIDTH+1 cycles after the accept edge.
REQ-016 In DONE, diff and bout SHALL be held stable; out_valid&&out_ready SHALL return the FSM to IDLE; when out_ready=0, DONE is held indefinitely.
REQ-017 in_valid in RUN or DONE SHALL be ignored (no capture, no corruption of the operation in flight).
REQ-018 Boundary cases: all-zero operands with bin=1 SHALL give diff all-ones with bout=1; a==b with bin=0 SHALL give zero with bout=0; a=2^WIDTH-1, b=0 SHALL give a with bout=0.
REQ-019 The counter width SHALL be $clog2(WIDTH), and the counter SHALL never wrap within one operation.

Reset
REQ-020 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and diff, bout, out_valid, the counter and the borrow register SHALL clear to 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-021 Reset during RUN or DONE SHALL abort the operation without emitting a result.

Configuration
REQ-022 With SERIAL_SUB_SAT_EN defined, a result with final borrow=1 SHALL present diff=0 (saturate at zero), with bout still reporting 1.
REQ-023 Without SERIAL_SUB_SAT_EN, diff SHALL be the modular result per REQ-010.

Structure
REQ-024 Package serial_sub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-025 The per-bit logic SHALL be a sub-module full_subtractor (inputs a, b, bin; outputs d, bo), instantiated once.

Verification (WIDTH=8)
REQ-026 a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, out_valid exactly 9 cycles after accept.
REQ-027 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; with SERIAL_SUB_SAT_EN: diff=0x00, bout=1.
REQ-028 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
REQ-029 out_ready held low 5 cycles in DONE -> diff/bout/out_valid stable; in_valid pulsed in RUN and DONE with other operands -> ignored, in_ready=0 throughout.
REQ-030 rst_n low for 1 cycle at the 4th RUN cycle -> next cycle IDLE, all outputs 0, in_ready=1; a following 0x10-0x01 operation -> diff=0x0F, bout=0.
